uart_tx_arbiter: RTL and testbench

Shares the single UART transmit path (TX FIFO write port plus CTS flow control) among NumReq byte-stream requesters. Grants are round-robin and packet-locked: the owner keeps the grant until its last byte, until it drops its request, or until MaxBurst bytes have been sent. The block sits between client engines and the UART TX FIFO write interface (write data, write enable, full).

---
 rtl/uart_tx_arbiter_pkg.sv | 9 +
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 97 +++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared constants and state type for the UART TX arbiter
package uart_pkg;
  localparam int ByteWidth = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and TX FIFO write-port bundle for the arbiter
interface uart_tx_arbiter_if #(
  parameter int NumReq = 4
);
  import uart_pkg::*;

  logic [NumReq-1:0]           i_req;
  logic [NumReq*ByteWidth-1:0] i_data;
  logic [NumReq-1:0]           i_last;
  logic [NumReq-1:0]           o_ack;
  logic [NumReq-1:0]           o_grant;
  logic [$clog2(NumReq)-1:0]   o_owner;
  logic                        o_busy;
  logic [ByteWidth-1:0]        o_tx_data;
  logic                        o_tx_req;
  logic                        i_tx_full;
  logic                        i_cts;

  modport master (
    output i_req, i_data, i_last, i_tx_full, i_cts,
    input  o_ack, o_grant, o_owner, o_busy, o_tx_data, o_tx_req
  );

  modport slave (
    input  i_req, i_data, i_last, i_tx_full, i_cts,
    output o_ack, o_grant, o_owner, o_busy, o_tx_data, o_tx_req
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker, first set bit from ptr upward
module rr_pick #(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         req_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [NumReq-1:0]         onehot_o,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      any_o
);
  localparam int IW = $clog2(NumReq);

  // Scan farthest offset first so the nearest requester from ptr overwrites last.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      int c;
      c = int'(ptr_i) + i;
      if (c >= NumReq) c = c - NumReq;
      if (req_i[c]) begin
        onehot_o    = '0;
        onehot_o[c] = 1'b1;
        idx_o       = IW'(c);
        any_o       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin sharing of the UART TX FIFO write port
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int MaxBurst = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_tx_arbiter_if.slave   bus
);
  localparam int OW = $clog2(NumReq);
  localparam int CW = $clog2(MaxBurst + 1);

  arb_state_e       state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    burst_q, burst_d;

  logic [NumReq-1:0] pick_onehot;
  logic [OW-1:0]     pick_idx;
  logic              pick_any;

  logic [NumReq-1:0]    ack_c, grant_c;
  logic                 busy_c, tx_req_c, release_c;
  logic [ByteWidth-1:0] tx_data_c;

  rr_pick #(.NumReq(NumReq)) u_rr_pick (
    .req_i    (bus.i_req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    ack_c     = '0;
    grant_c   = '0;
    busy_c    = 1'b0;
    tx_req_c  = 1'b0;
    tx_data_c = '0;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          burst_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        busy_c    = 1'b1;
        grant_c   = NumReq'(1) << owner_q;
        tx_data_c = bus.i_data[owner_q*ByteWidth +: ByteWidth];
        if (!bus.i_req[owner_q]) begin
          release_c = 1'b1;
        end else if (!bus.i_tx_full && bus.i_cts) begin
          tx_req_c = 1'b1;
          ack_c    = grant_c;
          burst_d  = (burst_q == CW'(MaxBurst)) ? burst_q : burst_q + CW'(1);
          // Last byte and burst limit on the same byte still yield a single release.
          if (bus.i_last[owner_q] || burst_q == CW'(MaxBurst - 1)) release_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (release_c) begin
      state_d = IDLE;
      ptr_d   = (owner_q == OW'(NumReq - 1)) ? '0 : owner_q + OW'(1);
    end
  end

  assign bus.o_ack     = ack_c;
  assign bus.o_grant   = grant_c;
  assign bus.o_busy    = busy_c;
  assign bus.o_owner   = busy_c ? owner_q : '0;
  assign bus.o_tx_req  = tx_req_c;
  assign bus.o_tx_data = tx_data_c;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed plus randomized scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 16;
  localparam int DEPTH = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NumReq(NR)) bus ();

  uart_tx_arbiter #(.NumReq(NR), .MaxBurst(MB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 1'b0;
  logic [NR-1:0] ack_s = '0;
  bit          prev_busy = 1'b0;
  logic [1:0]  prev_owner = '0;

  logic [7:0] bmem [NR][DEPTH];
  bit         lmem [NR][DEPTH];
  int         blen [NR];
  int         brd  [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      ack_s = bus.o_ack;
      if (bus.o_tx_req) begin
        check("sb_fifo_ok", 32'(!bus.i_tx_full && bus.i_cts), 32'd1);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", 32'(bus.o_tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_owner", 32'(bus.o_owner), 32'(e.owner));
          check("sb_data", 32'(bus.o_tx_data), 32'(e.data));
          check("sb_ack", 32'(bus.o_ack), 32'(1) << e.owner);
          check("sb_grant", 32'(bus.o_grant), 32'(1) << e.owner);
        end
      end else begin
        check("sb_ack_idle", 32'(bus.o_ack), 32'd0);
      end
      // A different owner may only appear after an idle cycle.
      if (prev_busy && bus.o_busy) check("sb_no_b2b", 32'(bus.o_owner), 32'(prev_owner));
      prev_busy  = bus.o_busy;
      prev_owner = bus.o_owner;
    end
  end

  task automatic set_byte(input int k, input logic [7:0] b, input bit l);
    bus.i_data[k*8 +: 8] = b;
    bus.i_last[k]        = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_model();
    int pos [NR];
    int ptr, left, k, rem, n;
    bit found;
    left = 0;
    for (int r = 0; r < NR; r++) begin
      int np;
      blen[r] = 0;
      brd[r]  = 0;
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        int len;
        len = (r == 0 && p == 0) ? 20 : $urandom_range(1, 22);
        for (int j = 0; j < len; j++) begin
          bmem[r][blen[r]] = 8'($urandom);
          lmem[r][blen[r]] = (j == len - 1);
          blen[r]++;
        end
      end
      pos[r] = 0;
      left += blen[r];
    end
    ptr = 0;
    while (left > 0) begin
      found = 1'b0;
      k = 0;
      for (int o = 0; o < NR; o++) begin
        if (!found && pos[(ptr + o) % NR] < blen[(ptr + o) % NR]) begin
          found = 1'b1;
          k = (ptr + o) % NR;
        end
      end
      rem = 0;
      for (int j = pos[k]; j < blen[k] && rem == 0; j++) if (lmem[k][j]) rem = j - pos[k] + 1;
      n = (rem < MB) ? rem : MB;
      for (int j = 0; j < n; j++) exp_q.push_back('{owner: 2'(k), data: bmem[k][pos[k] + j]});
      pos[k] += n;
      left   -= n;
      ptr     = (k + 1) % NR;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.i_req = '0; bus.i_data = '0; bus.i_last = '0;
    bus.i_tx_full = 1'b0; bus.i_cts = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(bus.o_grant), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_tx_req", 32'(bus.o_tx_req), 0);
    check("rst_ack", 32'(bus.o_ack), 0);
    check("rst_owner", 32'(bus.o_owner), 0);
    check("rst_tx_data", 32'(bus.o_tx_data), 0);
    rst = 1'b0;

    // Single requester, FIFO-full stall in the middle of the packet.
    tick();
    bus.i_req = 4'b0010; set_byte(1, 8'h41, 1'b0);
    @(negedge clk); check("t1_latency_idle", 32'(bus.o_busy), 0);
    tick();
    @(negedge clk);
    check("t1_grant", 32'(bus.o_grant), 32'h2);
    check("t1_b0_req", 32'(bus.o_tx_req), 1);
    check("t1_b0_data", 32'(bus.o_tx_data), 32'h41);
    check("t1_b0_ack", 32'(bus.o_ack), 32'h2);
    tick();
    set_byte(1, 8'h42, 1'b0); bus.i_tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_req", 32'(bus.o_tx_req), 0);
      check("t4_stall_ack", 32'(bus.o_ack), 0);
      check("t4_stall_grant", 32'(bus.o_grant), 32'h2);
      check("t4_stall_data", 32'(bus.o_tx_data), 32'h42);
      tick();
    end
    bus.i_tx_full = 1'b0;
    @(negedge clk);
    check("t4_resume_req", 32'(bus.o_tx_req), 1);
    check("t4_resume_data", 32'(bus.o_tx_data), 32'h42);
    tick();
    set_byte(1, 8'h43, 1'b1);
    @(negedge clk);
    check("t1_b2_data", 32'(bus.o_tx_data), 32'h43);
    check("t1_b2_ack", 32'(bus.o_ack), 32'h2);
    tick();
    bus.i_req = '0; bus.i_last = '0;
    @(negedge clk); check("t1_release", 32'(bus.o_busy), 0);

    // CTS stall with a competing requester, then owner drops its request.
    tick();
    bus.i_req = 4'b0001; set_byte(0, 8'h60, 1'b0);
    tick();
    @(negedge clk); check("t5_b0_ack", 32'(bus.o_ack), 32'h1);
    tick();
    bus.i_cts = 1'b0; bus.i_req = 4'b1001; set_byte(0, 8'h61, 1'b0); set_byte(3, 8'h70, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_cts_grant", 32'(bus.o_grant), 32'h1);
      check("t5_cts_req", 32'(bus.o_tx_req), 0);
      tick();
    end
    bus.i_cts = 1'b1;
    @(negedge clk);
    check("t5_resume_data", 32'(bus.o_tx_data), 32'h61);
    check("t5_resume_ack", 32'(bus.o_ack), 32'h1);
    tick();
    bus.i_req = 4'b1000;
    @(negedge clk);
    check("t5_drop_ack", 32'(bus.o_ack), 0);
    check("t5_drop_txreq", 32'(bus.o_tx_req), 0);
    tick();
    @(negedge clk); check("t5_drop_idle", 32'(bus.o_busy), 0);
    tick();
    @(negedge clk);
    check("t5_r3_grant", 32'(bus.o_grant), 32'h8);
    check("t5_r3_owner", 32'(bus.o_owner), 3);
    check("t5_r3_data", 32'(bus.o_tx_data), 32'h70);
    tick();
    bus.i_req = '0;
    tick();

    // Asynchronous reset mid-packet.
    bus.i_req = 4'b0001; set_byte(0, 8'h80, 1'b0);
    tick();
    @(negedge clk); check("t6_busy_before", 32'(bus.o_busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_txreq", 32'(bus.o_tx_req), 0);
    check("t6_rst_grant", 32'(bus.o_grant), 0);
    check("t6_rst_busy", 32'(bus.o_busy), 0);
    check("t6_rst_ack", 32'(bus.o_ack), 0);
    @(negedge clk);
    rst = 1'b0; bus.i_req = 4'b0100; set_byte(2, 8'h90, 1'b1);
    tick();
    @(negedge clk);
    check("t6_r2_grant", 32'(bus.o_grant), 32'h4);
    check("t6_r2_owner", 32'(bus.o_owner), 2);
    tick();
    bus.i_req = '0; bus.i_last = '0;
    tick();

    // Randomized traffic against the packet-level round-robin model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    build_model();
    ack_s = '0; prev_busy = 1'b0; mon_en = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 5000) begin
      @(posedge clk);
      for (int k = 0; k < NR; k++) if (ack_s[k]) brd[k]++;
      #1;
      for (int k = 0; k < NR; k++) begin
        bus.i_req[k] = brd[k] < blen[k];
        set_byte(k, (brd[k] < blen[k]) ? bmem[k][brd[k]] : 8'h00,
                    (brd[k] < blen[k]) ? lmem[k][brd[k]] : 1'b0);
      end
      bus.i_tx_full = $urandom_range(0, 99) < 30;
      bus.i_cts     = $urandom_range(0, 99) >= 20;
      cyc++;
    end
    check("rand_drain", 32'(exp_q.size()), 0);
    bus.i_req = '0; bus.i_last = '0; bus.i_tx_full = 1'b0; bus.i_cts = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    check("rand_final_idle", 32'(bus.o_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
